// File: rtl/cdc_pkg.sv
// Shared types and constants for the axi_cdc / axis_pkt_fifo clock-domain slice.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } pkt_state_t;

    localparam int STAT_W     = 16;
    localparam int WIDTH_M    = 32;
    localparam int WIDTH_S    = 32;
    localparam int FIFO_DEPTH = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream beat bundle (data/valid/last/ready) with producer and consumer views.
interface axis_pkt_fifo_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             last;
    logic             ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_pkt_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module pkt_fifo_mem #(
    parameter int DW    = 33,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO; oversize packets are dropped, never backpressured.
// Optional statistics counters are enabled with `define AXIS_PKT_FIFO_STATS_EN.
module axis_pkt_fifo
    import cdc_pkg::*;
#(
    parameter int WIDTH = WIDTH_S,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic              clk_s,
    input  logic              nrst_s,
    axis_pkt_fifo_if.slave    s_axis,
    axis_pkt_fifo_if.master   m_axis,
    output logic              pkt_avail,
    output logic              drop_pulse
`ifdef AXIS_PKT_FIFO_STATS_EN
    ,
    output logic [STAT_W-1:0] pkt_cnt,
    output logic [STAT_W-1:0] drop_cnt
`endif
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    pkt_state_t  state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] wr_commit_q, wr_commit_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] pkt_q, pkt_d;
    logic        s_rdy_q;
    logic        drop_q, drop_d;

    logic [AW:0]    used_s;
    logic           accept_s;
    logic           has_space_s;
    logic           wr_en_s;
    logic           commit_s;
    logic           m_valid_s;
    logic           rd_fire_s;
    logic [WIDTH:0] rdata_s;

    assign accept_s    = s_rdy_q & s_axis.valid;
    assign used_s      = wr_ptr_q - rd_ptr_q;
    assign has_space_s = (used_s < FULL_LVL);

    // Write-side packet FSM: store, commit on last, or rewind and discard when full
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        wr_en_s     = 1'b0;
        commit_s    = 1'b0;
        drop_d      = 1'b0;
        case (state_q)
            IDLE, WRITE: begin
                if (accept_s && has_space_s) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (s_axis.last) begin
                        wr_commit_d = wr_ptr_q + PTR_ONE;
                        commit_s    = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = WRITE;
                    end
                end else if (accept_s) begin
                    wr_ptr_d = wr_commit_q;
                    if (s_axis.last) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DROP: begin
                if (accept_s && s_axis.last) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_ptr_d = wr_commit_q;
            end
        endcase
    end

    assign m_valid_s = (rd_ptr_q != wr_commit_q);
    assign rd_fire_s = m_valid_s & m_axis.ready;

    // Read pointer advance and committed-packet bookkeeping
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        pkt_d    = pkt_q;
        if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({commit_s, rd_fire_s & rdata_s[WIDTH]})
            2'b10:   pkt_d = pkt_q + PTR_ONE;
            2'b01:   pkt_d = pkt_q - PTR_ONE;
            default: pkt_d = pkt_q;
        endcase
    end

    // State and pointer registers with synchronous active-low reset
    always_ff @(posedge clk_s) begin
        if (!nrst_s) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pkt_q       <= '0;
            s_rdy_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_q       <= pkt_d;
            s_rdy_q     <= 1'b1;
            drop_q      <= drop_d;
        end
    end

    pkt_fifo_mem #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_s),
        .we_i    (wr_en_s),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({s_axis.last, s_axis.data}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rdata_s)
    );

    assign s_axis.ready = s_rdy_q;
    assign m_axis.valid = m_valid_s;
    assign m_axis.data  = rdata_s[WIDTH-1:0];
    // Stale memory contents must not show a last flag while nothing is presented
    assign m_axis.last  = m_valid_s & rdata_s[WIDTH];
    assign pkt_avail    = (pkt_q != '0);
    assign drop_pulse   = drop_q;

`ifdef AXIS_PKT_FIFO_STATS_EN
    logic [STAT_W-1:0] pkt_cnt_q;
    logic [STAT_W-1:0] drop_cnt_q;

    // Saturating commit and drop counters
    always_ff @(posedge clk_s) begin
        if (!nrst_s) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (commit_s) begin
                pkt_cnt_q <= sat_inc(pkt_cnt_q);
            end
            if (drop_q) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Randomized scoreboard bench for axis_pkt_fifo against a queue-based packet model.
module tb_axis_pkt_fifo;
    localparam int W = 32;
    localparam int D = 16;

    logic clk_s = 1'b0;
    logic nrst_s;
    logic pkt_avail;
    logic drop_pulse;
`ifdef AXIS_PKT_FIFO_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
`endif

    axis_pkt_fifo_if #(.WIDTH(W)) s_if ();
    axis_pkt_fifo_if #(.WIDTH(W)) m_if ();

    axis_pkt_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_s      (clk_s),
        .nrst_s     (nrst_s),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .pkt_avail  (pkt_avail),
        .drop_pulse (drop_pulse)
`ifdef AXIS_PKT_FIFO_STATS_EN
        ,
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk_s = ~clk_s;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int rmode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: committed beats, packet being received, expected output stream
    logic [W:0] mq[$];
    logic [W:0] cur[$];
    logic [W:0] exp_q[$];
    int  pkts_m = 0;
    bit  dropping = 1'b0;
    bit  drop_m = 1'b0;
    bit  rdy_m = 1'b0;

    initial begin : model
        bit acc, rd, commit;
        logic [W:0] b;
        forever begin
            @(negedge clk_s);
            if (chk_en) begin
                chk("s_ready", 64'(s_if.ready), 64'(rdy_m));
                chk("m_valid", 64'(m_if.valid), 64'(mq.size() > 0));
                chk("pkt_avail", 64'(pkt_avail), 64'(pkts_m > 0));
                chk("drop_pulse", 64'(drop_pulse), 64'(drop_m));
            end
            if (!nrst_s) begin
                mq.delete(); cur.delete(); exp_q.delete();
                pkts_m = 0; dropping = 1'b0; drop_m = 1'b0; rdy_m = 1'b0;
            end else begin
                acc = rdy_m && s_if.valid;
                rd = (mq.size() > 0) && m_if.ready;
                commit = 1'b0;
                drop_m = 1'b0;
                if (acc) begin
                    if (dropping) begin
                        if (s_if.last) begin drop_m = 1'b1; dropping = 1'b0; end
                    end else if (mq.size() + cur.size() < D) begin
                        cur.push_back({s_if.last, s_if.data});
                        commit = s_if.last;
                    end else begin
                        cur.delete();
                        if (s_if.last) drop_m = 1'b1;
                        else dropping = 1'b1;
                    end
                end
                if (rd) begin
                    b = mq.pop_front();
                    if (b[W]) pkts_m--;
                end
                if (commit) begin
                    foreach (cur[i]) begin
                        mq.push_back(cur[i]);
                        exp_q.push_back(cur[i]);
                    end
                    cur.delete();
                    pkts_m++;
                end
                rdy_m = 1'b1;
            end
        end
    end

    // Monitor: pop expected beat on every output handshake, check hold-while-stalled
    initial begin : monitor
        bit stall_prev = 1'b0;
        logic [W-1:0] prev_data;
        logic prev_last;
        logic [W:0] e;
        forever begin
            @(negedge clk_s);
            if (chk_en && nrst_s) begin
                if (stall_prev) begin
                    chk("hold_valid", 64'(m_if.valid), 64'd1);
                    chk("hold_data", 64'(m_if.data), 64'(prev_data));
                    chk("hold_last", 64'(m_if.last), 64'(prev_last));
                end
                if (!m_if.valid) chk("idle_last", 64'(m_if.last), 64'd0);
                if (m_if.valid && m_if.ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(m_if.data), 64'hDEAD_BEEF_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 64'(m_if.data), 64'(e[W-1:0]));
                        chk("out_last", 64'(m_if.last), 64'(e[W]));
                    end
                end
                stall_prev = m_if.valid && !m_if.ready;
                prev_data = m_if.data;
                prev_last = m_if.last;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Sole driver of the consumer ready line
    initial begin : ready_drv
        m_if.ready = 1'b0;
        forever begin
            @(posedge clk_s); #1;
            case (rmode)
                0: m_if.ready = 1'b1;
                1: m_if.ready = 1'b0;
                2: m_if.ready = !m_if.ready;
                default: m_if.ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_s); #1; end
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l, input int gapmax);
        int n = 0;
        while (!s_if.ready && n < 50) begin tick(1); n++; end
        if (n >= 50) chk("s_ready_wait", 64'(s_if.ready), 64'd1);
        s_if.valid = 1'b1; s_if.data = d; s_if.last = l;
        tick(1);
        s_if.valid = 1'b0; s_if.last = 1'b0;
        tick($urandom_range(0, gapmax));
    endtask

    task automatic send_pkt(input int len, input logic [W-1:0] base, input int gapmax);
        for (int i = 0; i < len; i++) send_beat(base + W'(i), (i == len - 1), gapmax);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((mq.size() > 0 || exp_q.size() > 0) && n < budget) begin tick(1); n++; end
        chk("drain_left", 64'(mq.size() + exp_q.size()), 64'd0);
        tick(2);
    endtask

    task automatic do_reset(input int cyc);
        nrst_s = 1'b0;
        tick(cyc);
        nrst_s = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0;
        nrst_s = 1'b0;
        tick(2);
        nrst_s = 1'b1;
        chk_en = 1'b1;
        tick(2);

        rmode = 0;
        send_pkt(4, 32'hA0, 0);
        drain(100);

        send_pkt(20, 32'hC0, 0);
        send_pkt(3, 32'hB0, 0);
        drain(100);

        rmode = 1; tick(1);
        for (int p = 0; p < 4; p++) send_pkt(5, 32'h100 * (p + 1), 0);
        tick(3);
        chk("backlog_beats", 64'(exp_q.size()), 64'd15);
        rmode = 0;
        drain(100);

        rmode = 2;
        for (int p = 0; p < 4; p++) send_pkt(8, 32'h5000 + 32'h10 * p, 1);
        drain(200);

        rmode = 0;
        send_beat(32'hE0, 1'b0, 0);
        send_beat(32'hE1, 1'b0, 0);
        do_reset(2);
        tick(1);
        send_pkt(4, 32'hF0, 0);
        drain(100);

        rmode = 3;
        for (int p = 0; p < 25; p++) send_pkt($urandom_range(1, 20), $urandom, 2);
        rmode = 0;
        drain(400);

        do_reset(2);
        tick(1);
        for (int p = 0; p < 3; p++) send_pkt(3, 32'h7000 + 32'h10 * p, 0);
        send_pkt(18, 32'h8000, 0);
        send_pkt(17, 32'h9000, 0);
        drain(200);
`ifdef AXIS_PKT_FIFO_STATS_EN
        chk("pkt_cnt", 64'(pkt_cnt), 64'd3);
        chk("drop_cnt", 64'(drop_cnt), 64'd2);
`endif
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
